// File: rtl/cfg_stream_loader_if.sv
// Bundle of the serial configuration stream (in and out), the tile memory
// write port and the loader status flags for one cfg_stream_loader tile.
interface cfg_stream_loader_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 8
);
    logic              data_in;
    logic              data_valid;
    logic              data_out;
    logic              data_valid_out;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              load_done;
    logic              overrun;

    modport master (
        output data_in, data_valid,
        input  data_out, data_valid_out, mem_we, mem_addr, mem_wdata, load_done, overrun
    );

    modport slave (
        input  data_in, data_valid,
        output data_out, data_valid_out, mem_we, mem_addr, mem_wdata, load_done, overrun
    );
endinterface

// File: rtl/cfg_stream_loader.sv
// One tile of the CGRA serial configuration chain: forwards the bit stream
// registered and deserialises this tile's window into configuration words.
module cfg_stream_loader #(
    parameter int NUM_TILES = 9,
    parameter int TILE_ID   = 0,
    parameter int WORD_W    = 16,
    parameter int DEPTH     = 256
) (
    input  logic                clk,
    input  logic                rst,
    cfg_stream_loader_if.slave  bus
);
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIN_BITS   = DEPTH * WORD_W;
    localparam int WIN_START  = NUM_TILES + TILE_ID * WIN_BITS;
    localparam int TOTAL_BITS = NUM_TILES + NUM_TILES * WIN_BITS;
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
    localparam int POS_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(WIN_START);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIN_START + WIN_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_TOTAL = CNT_W'(TOTAL_BITS);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        SKIP,
        LOAD,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [POS_W-1:0]   bit_pos;
    logic [WORD_W-1:0]  sreg;
    logic [WORD_W-1:0]  sreg_next;
    logic [ADDR_W-1:0]  word_idx;
    logic               capture;

    // The incoming bit is placed at its word position, so the first bit of
    // each word lands in bit 0 and stale bits are overwritten before reuse.
    always_comb begin
        sreg_next          = sreg;
        sreg_next[bit_pos] = bus.data_in;
        capture            = bus.data_valid &&
                             ((state == LOAD) || (state == SKIP && bit_cnt == CNT_START));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= SKIP;
            bit_cnt            <= '0;
            bit_pos            <= '0;
            sreg               <= '0;
            word_idx           <= '0;
            bus.data_out       <= 1'b0;
            bus.data_valid_out <= 1'b0;
            bus.mem_we         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_wdata      <= '0;
            bus.load_done      <= 1'b0;
            bus.overrun        <= 1'b0;
        end else begin
            bus.data_out       <= bus.data_in;
            bus.data_valid_out <= bus.data_valid;
            bus.mem_we         <= 1'b0;

            // Counter saturates at the stream length; any further valid bit is an overrun.
            if (bus.data_valid) begin
                if (bit_cnt == CNT_TOTAL) begin
                    bus.overrun <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            if (capture) begin
                sreg <= sreg_next;
                if (bit_pos == POS_LAST) begin
                    bit_pos       <= '0;
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= word_idx;
                    bus.mem_wdata <= sreg_next;
                    if (word_idx != IDX_LAST) begin
                        word_idx <= word_idx + ADDR_W'(1);
                    end
                end else begin
                    bit_pos <= bit_pos + POS_W'(1);
                end

                if (bit_cnt == CNT_LAST) begin
                    state         <= DONE;
                    bus.load_done <= 1'b1;
                end else begin
                    state <= LOAD;
                end
            end
        end
    end
endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench: a three-tile chain exercised with a table of per-cycle vectors
// plus hand-written gapped, overrun and mid-load reset sequences.
module tb_cfg_stream_loader;
    localparam int NT = 3;
    localparam int WW = 4;
    localparam int DP = 2;
    localparam int AW = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cfg_stream_loader_if #(.WORD_W(WW), .ADDR_W(AW)) if0 ();
    cfg_stream_loader_if #(.WORD_W(WW), .ADDR_W(AW)) if1 ();
    cfg_stream_loader_if #(.WORD_W(WW), .ADDR_W(AW)) if2 ();

    assign if1.data_in    = if0.data_out;
    assign if1.data_valid = if0.data_valid_out;
    assign if2.data_in    = if1.data_out;
    assign if2.data_valid = if1.data_valid_out;

    cfg_stream_loader #(.NUM_TILES(NT), .TILE_ID(0), .WORD_W(WW), .DEPTH(DP)) c0 (
        .clk(clk), .rst(rst), .bus(if0));
    cfg_stream_loader #(.NUM_TILES(NT), .TILE_ID(1), .WORD_W(WW), .DEPTH(DP)) c1 (
        .clk(clk), .rst(rst), .bus(if1));
    cfg_stream_loader #(.NUM_TILES(NT), .TILE_ID(2), .WORD_W(WW), .DEPTH(DP)) c2 (
        .clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        logic       r;
        logic       d;
        logic       v;
        logic [2:0] we;
        logic [2:0] done;
        logic [3:0] wdata;
        logic       addr;
    } vec_t;

    vec_t tbl [31];
    int checks = 0;
    int errors = 0;

    // Stream bit k is s_bits[k]: preamble, tile0 D/8, tile1 D/8, tile2 6/F.
    logic [0:26] s_bits = 27'b000_10110001_10110001_01101111;
    // Replacement tile0 stream for the mid-load reset: words E then 3.
    logic [0:10] n_bits = 11'b000_0111_1100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic d, input logic v);
        rst            = r;
        if0.data_in    = d;
        if0.data_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       dr;
        logic       ew;
        logic [3:0] act_wd;
        logic       act_ad;

        // Two reset rows with activity on the inputs, then the continuous stream.
        tbl[0] = '{r: 1'b0, d: 1'b1, v: 1'b1, we: 3'b000, done: 3'b000, wdata: 4'h0, addr: 1'b0};
        tbl[1] = '{r: 1'b0, d: 1'b0, v: 1'b1, we: 3'b000, done: 3'b000, wdata: 4'h0, addr: 1'b0};
        for (int k = 0; k < 29; k++) begin
            tbl[2+k].r     = 1'b1;
            tbl[2+k].d     = (k < 27) ? s_bits[k] : 1'b0;
            tbl[2+k].v     = (k < 27);
            tbl[2+k].we    = 3'b000;
            tbl[2+k].done  = {k >= 28, k >= 19, k >= 10};
            tbl[2+k].wdata = 4'h0;
            tbl[2+k].addr  = 1'b0;
        end
        tbl[2+6].we  = 3'b001; tbl[2+6].wdata  = 4'hD; tbl[2+6].addr  = 1'b0;
        tbl[2+10].we = 3'b001; tbl[2+10].wdata = 4'h8; tbl[2+10].addr = 1'b1;
        tbl[2+15].we = 3'b010; tbl[2+15].wdata = 4'hD; tbl[2+15].addr = 1'b0;
        tbl[2+19].we = 3'b010; tbl[2+19].wdata = 4'h8; tbl[2+19].addr = 1'b1;
        tbl[2+24].we = 3'b100; tbl[2+24].wdata = 4'h6; tbl[2+24].addr = 1'b0;
        tbl[2+28].we = 3'b100; tbl[2+28].wdata = 4'hF; tbl[2+28].addr = 1'b1;

        for (int i = 0; i < 31; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].v);
            chk($sformatf("we[%0d]", i), 32'({if2.mem_we, if1.mem_we, if0.mem_we}), 32'(tbl[i].we));
            chk($sformatf("done[%0d]", i), 32'({if2.load_done, if1.load_done, if0.load_done}),
                32'(tbl[i].done));
            chk($sformatf("dout[%0d]", i), 32'(if0.data_out), 32'(tbl[i].r & tbl[i].d));
            chk($sformatf("dvout[%0d]", i), 32'(if0.data_valid_out), 32'(tbl[i].r & tbl[i].v));
            if (tbl[i].we != 3'b000) begin
                if (tbl[i].we[0]) begin
                    act_wd = if0.mem_wdata; act_ad = if0.mem_addr;
                end else if (tbl[i].we[1]) begin
                    act_wd = if1.mem_wdata; act_ad = if1.mem_addr;
                end else begin
                    act_wd = if2.mem_wdata; act_ad = if2.mem_addr;
                end
                chk($sformatf("wdata[%0d]", i), 32'(act_wd), 32'(tbl[i].wdata));
                chk($sformatf("addr[%0d]", i), 32'(act_ad), 32'(tbl[i].addr));
            end
            if (!tbl[i].r) begin
                chk("rst_addr_wdata", 32'({if0.mem_addr, if0.mem_wdata, if1.mem_wdata, if2.mem_wdata}), 32'(0));
                chk("rst_overrun", 32'({if2.overrun, if1.overrun, if0.overrun}), 32'(0));
                chk("rst_bit_cnt", 32'(c0.bit_cnt), 32'(0));
            end
        end
        chk("chain_no_overrun", 32'({if2.overrun, if1.overrun, if0.overrun}), 32'(0));

        // One valid bit past the full stream: each tile flags overrun as it arrives.
        step(1'b1, 1'b1, 1'b1);
        chk("ovr_tile0", 32'(if0.overrun), 32'(1));
        chk("ovr_we0", 32'(if0.mem_we), 32'(0));
        chk("ovr_bit_cnt", 32'(c0.bit_cnt), 32'(27));
        chk("ovr_tile1_early", 32'(if1.overrun), 32'(0));
        step(1'b1, 1'b0, 1'b0);
        chk("ovr_tile1", 32'(if1.overrun), 32'(1));
        chk("ovr_we1", 32'(if1.mem_we), 32'(0));
        step(1'b1, 1'b0, 1'b0);
        chk("ovr_tile2", 32'(if2.overrun), 32'(1));
        chk("ovr_bit_cnt_hold", 32'(c0.bit_cnt), 32'(27));

        // Gapped stream into tile 0 with random data on the invalid cycles.
        step(1'b0, 1'b0, 1'b0);
        chk("gap_rst_overrun", 32'(if0.overrun), 32'(0));
        for (int k = 0; k < 11; k++) begin
            step(1'b1, s_bits[k], 1'b1);
            ew = (k == 6) || (k == 10);
            chk($sformatf("gap_we[%0d]", k), 32'(if0.mem_we), 32'(ew));
            if (ew) begin
                chk($sformatf("gap_addr[%0d]", k), 32'(if0.mem_addr), 32'(k == 10));
                chk($sformatf("gap_wdata[%0d]", k), 32'(if0.mem_wdata), (k == 6) ? 32'hD : 32'h8);
            end
            chk($sformatf("gap_done[%0d]", k), 32'(if0.load_done), 32'(k >= 10));
            chk($sformatf("gap_dout[%0d]", k), 32'(if0.data_out), 32'(s_bits[k]));
            chk($sformatf("gap_dvout[%0d]", k), 32'(if0.data_valid_out), 32'(1));
            for (int g = 0; g < 5; g++) begin
                dr = 1'($urandom);
                step(1'b1, dr, 1'b0);
                chk("gap_idle_we", 32'(if0.mem_we), 32'(0));
                chk("gap_idle_dout", 32'(if0.data_out), 32'(dr));
                chk("gap_idle_dvout", 32'(if0.data_valid_out), 32'(0));
            end
        end

        // Mid-load reset: old stream through bit 6, reset colliding with a valid bit, new stream.
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step(1'b1, s_bits[k], 1'b1);
        end
        chk("mid_old_we", 32'(if0.mem_we), 32'(1));
        step(1'b0, 1'b1, 1'b1);
        chk("mid_rst_bit_cnt", 32'(c0.bit_cnt), 32'(0));
        chk("mid_rst_done", 32'(if0.load_done), 32'(0));
        chk("mid_rst_we", 32'(if0.mem_we), 32'(0));
        for (int k = 0; k < 11; k++) begin
            step(1'b1, n_bits[k], 1'b1);
            ew = (k == 6) || (k == 10);
            chk($sformatf("mid_we[%0d]", k), 32'(if0.mem_we), 32'(ew));
            if (ew) begin
                chk($sformatf("mid_addr[%0d]", k), 32'(if0.mem_addr), 32'(k == 10));
                chk($sformatf("mid_wdata[%0d]", k), 32'(if0.mem_wdata), (k == 6) ? 32'hE : 32'h3);
            end
            chk($sformatf("mid_done[%0d]", k), 32'(if0.load_done), 32'(k >= 10));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
